// File: rtl/ip_pkg.sv
// Shared IP-layer definitions for the TX arbiter and its neighbours.
//   - IP protocol numbers carried on tx_ip_proto
//   - AXI-Stream tdest encoding of the traffic source (same as the RX path)
//   - Arbiter FSM state encoding
package ip_pkg;

    localparam logic [7:0] IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0] IP_PROTO_ICMP = 8'd1;

    localparam logic TDEST_UDP  = 1'b0;
    localparam logic TDEST_ICMP = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2,
        ST_FLUSH = 2'd3
    } tx_arb_state_e;

    // Protocol number for a source, keyed by its tdest encoding.
    function automatic logic [7:0] proto_of(input logic src);
        return (src == TDEST_ICMP) ? IP_PROTO_ICMP : IP_PROTO_UDP;
    endfunction

endpackage

// File: rtl/ip_tx_arbiter_stall_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and raises
// fire combinationally on the cycle that would make the count reach TERMINAL.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (has priority over en)
//   en       : count this cycle
//   fire     : this enabled cycle is the TERMINAL-th since the last clear
module stall_watchdog #(
    parameter logic [15:0] TERMINAL = 16'd4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic fire
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Firing on TERMINAL-1 lets the owner register its reaction on the same
    // edge that the count reaches TERMINAL.
    assign fire = en && !clr && (cnt_q == (TERMINAL - 16'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the IP TX path between the UDP
// and ICMP transmitters (tx_mac_aclk domain).
//   udp_* / icmp_*      : source metadata (dst, len) and byte streams
//   tx_ip_proto/dst/len : metadata latched at grant, held until next grant
//   tx_axis_ip_*        : stream to the IP framer; tuser marks an abort beat,
//                         tdest identifies the source (0 UDP, 1 ICMP)
//   tx_busy             : arbiter not idle
//   tx_abort            : one-cycle pulse in the first ABORT cycle
module ip_tx_arbiter
    import ip_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
    input  logic        tx_mac_aclk,
    input  logic        tx_mac_reset,
    input  logic [31:0] udp_tx_ip_dst,
    input  logic [15:0] udp_tx_ip_len,
    input  logic [7:0]  udp_axis_tdata,
    input  logic        udp_axis_tvalid,
    input  logic        udp_axis_tlast,
    output logic        udp_axis_tready,
    input  logic [31:0] icmp_tx_ip_dst,
    input  logic [15:0] icmp_tx_ip_len,
    input  logic [7:0]  icmp_axis_tdata,
    input  logic        icmp_axis_tvalid,
    input  logic        icmp_axis_tlast,
    output logic        icmp_axis_tready,
    output logic [7:0]  tx_ip_proto,
    output logic [31:0] tx_ip_dst,
    output logic [15:0] tx_ip_len,
    output logic [7:0]  tx_axis_ip_tdata,
    output logic        tx_axis_ip_tvalid,
    output logic        tx_axis_ip_tlast,
    input  logic        tx_axis_ip_tready,
    output logic        tx_axis_ip_tuser,
    output logic        tx_axis_ip_tdest,
    output logic        tx_busy,
    output logic        tx_abort
);

    tx_arb_state_e state_q, state_d;
    // grant_q doubles as last_grant: in IDLE it still holds the previous winner.
    logic          grant_q, grant_d;
    logic          tdest_q, tdest_d;
    logic [7:0]    proto_q, proto_d;
    logic [31:0]   dst_q, dst_d;
    logic [15:0]   len_q, len_d;
    logic          abort_q, abort_d;

    logic [7:0]    src_tdata;
    logic          src_tvalid;
    logic          src_tlast;
    logic          src_tready;
    logic          winner;
    logic          wd_fire;
    logic          wd_en;
    logic          wd_clr;

    assign src_tdata  = (grant_q == TDEST_ICMP) ? icmp_axis_tdata  : udp_axis_tdata;
    assign src_tvalid = (grant_q == TDEST_ICMP) ? icmp_axis_tvalid : udp_axis_tvalid;
    assign src_tlast  = (grant_q == TDEST_ICMP) ? icmp_axis_tlast  : udp_axis_tlast;

    // Only source starvation counts; downstream backpressure keeps tvalid high.
    assign wd_en  = (state_q == ST_XFER) && !src_tvalid;
    assign wd_clr = (state_q != ST_XFER) || src_tvalid;

    stall_watchdog #(
        .TERMINAL(TIMEOUT_CYC)
    ) u_stall_watchdog (
        .clk  (tx_mac_aclk),
        .rst  (tx_mac_reset),
        .clr  (wd_clr),
        .en   (wd_en),
        .fire (wd_fire)
    );

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        tdest_d           = tdest_q;
        proto_d           = proto_q;
        dst_d             = dst_q;
        len_d             = len_q;
        abort_d           = 1'b0;
        winner            = TDEST_UDP;
        src_tready        = 1'b0;
        tx_axis_ip_tdata  = 8'h00;
        tx_axis_ip_tvalid = 1'b0;
        tx_axis_ip_tlast  = 1'b0;
        tx_axis_ip_tuser  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (udp_axis_tvalid || icmp_axis_tvalid) begin
                    if (udp_axis_tvalid && icmp_axis_tvalid) begin
                        winner = ~grant_q;
                    end else begin
                        winner = icmp_axis_tvalid ? TDEST_ICMP : TDEST_UDP;
                    end
                    grant_d = winner;
                    tdest_d = winner;
                    proto_d = proto_of(winner);
                    dst_d   = (winner == TDEST_ICMP) ? icmp_tx_ip_dst : udp_tx_ip_dst;
                    len_d   = (winner == TDEST_ICMP) ? icmp_tx_ip_len : udp_tx_ip_len;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                tx_axis_ip_tdata  = src_tdata;
                tx_axis_ip_tvalid = src_tvalid;
                tx_axis_ip_tlast  = src_tlast;
                src_tready        = tx_axis_ip_tready;
                if (src_tvalid && tx_axis_ip_tready && src_tlast) begin
                    state_d = ST_IDLE;
                end else if (wd_fire) begin
                    abort_d = 1'b1;
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                tx_axis_ip_tvalid = 1'b1;
                tx_axis_ip_tlast  = 1'b1;
                tx_axis_ip_tuser  = 1'b1;
                if (tx_axis_ip_tready) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Drain the rest of the stalled packet so the source can recover.
                src_tready = 1'b1;
                if (src_tvalid && src_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign udp_axis_tready  = src_tready && (grant_q == TDEST_UDP);
    assign icmp_axis_tready = src_tready && (grant_q == TDEST_ICMP);
    assign tx_axis_ip_tdest = tdest_q;
    assign tx_ip_proto      = proto_q;
    assign tx_ip_dst        = dst_q;
    assign tx_ip_len        = len_q;
    assign tx_busy          = (state_q != ST_IDLE);
    assign tx_abort         = abort_q;

    always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset) begin
        if (tx_mac_reset) begin
            state_q <= ST_IDLE;
            grant_q <= TDEST_ICMP;
            tdest_q <= 1'b0;
            proto_q <= 8'd0;
            dst_q   <= 32'd0;
            len_q   <= 16'd0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            tdest_q <= tdest_d;
            proto_q <= proto_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed self-checking bench for ip_tx_arbiter (TIMEOUT_CYC = 10).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_ip_tx_arbiter;

    localparam logic [31:0] UDP_DST  = 32'hC0A8_0102;
    localparam logic [15:0] UDP_LEN  = 16'd8;
    localparam logic [31:0] ICMP_DST = 32'h0A00_0001;
    localparam logic [15:0] ICMP_LEN = 16'd16;

    logic        clk;
    logic        rst;
    logic [31:0] udp_tx_ip_dst;
    logic [15:0] udp_tx_ip_len;
    logic [7:0]  udp_axis_tdata;
    logic        udp_axis_tvalid;
    logic        udp_axis_tlast;
    logic        udp_axis_tready;
    logic [31:0] icmp_tx_ip_dst;
    logic [15:0] icmp_tx_ip_len;
    logic [7:0]  icmp_axis_tdata;
    logic        icmp_axis_tvalid;
    logic        icmp_axis_tlast;
    logic        icmp_axis_tready;
    logic [7:0]  tx_ip_proto;
    logic [31:0] tx_ip_dst;
    logic [15:0] tx_ip_len;
    logic [7:0]  tx_axis_ip_tdata;
    logic        tx_axis_ip_tvalid;
    logic        tx_axis_ip_tlast;
    logic        tx_axis_ip_tready;
    logic        tx_axis_ip_tuser;
    logic        tx_axis_ip_tdest;
    logic        tx_busy;
    logic        tx_abort;

    int total = 0;
    int bad   = 0;

    ip_tx_arbiter #(
        .TIMEOUT_CYC(16'd10)
    ) dut (
        .tx_mac_aclk       (clk),
        .tx_mac_reset      (rst),
        .udp_tx_ip_dst     (udp_tx_ip_dst),
        .udp_tx_ip_len     (udp_tx_ip_len),
        .udp_axis_tdata    (udp_axis_tdata),
        .udp_axis_tvalid   (udp_axis_tvalid),
        .udp_axis_tlast    (udp_axis_tlast),
        .udp_axis_tready   (udp_axis_tready),
        .icmp_tx_ip_dst    (icmp_tx_ip_dst),
        .icmp_tx_ip_len    (icmp_tx_ip_len),
        .icmp_axis_tdata   (icmp_axis_tdata),
        .icmp_axis_tvalid  (icmp_axis_tvalid),
        .icmp_axis_tlast   (icmp_axis_tlast),
        .icmp_axis_tready  (icmp_axis_tready),
        .tx_ip_proto       (tx_ip_proto),
        .tx_ip_dst         (tx_ip_dst),
        .tx_ip_len         (tx_ip_len),
        .tx_axis_ip_tdata  (tx_axis_ip_tdata),
        .tx_axis_ip_tvalid (tx_axis_ip_tvalid),
        .tx_axis_ip_tlast  (tx_axis_ip_tlast),
        .tx_axis_ip_tready (tx_axis_ip_tready),
        .tx_axis_ip_tuser  (tx_axis_ip_tuser),
        .tx_axis_ip_tdest  (tx_axis_ip_tdest),
        .tx_busy           (tx_busy),
        .tx_abort          (tx_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL sim_time_limit reached before summary");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic src, input logic v, input logic [7:0] d, input logic l);
        if (src) begin
            icmp_axis_tvalid = v;
            icmp_axis_tdata  = d;
            icmp_axis_tlast  = l;
        end else begin
            udp_axis_tvalid = v;
            udp_axis_tdata  = d;
            udp_axis_tlast  = l;
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_udp_tready"},  32'(udp_axis_tready), 32'd0);
        chk({pfx, "_icmp_tready"}, 32'(icmp_axis_tready), 32'd0);
        chk({pfx, "_tvalid"},      32'(tx_axis_ip_tvalid), 32'd0);
        chk({pfx, "_tlast"},       32'(tx_axis_ip_tlast), 32'd0);
        chk({pfx, "_tuser"},       32'(tx_axis_ip_tuser), 32'd0);
        chk({pfx, "_busy"},        32'(tx_busy), 32'd0);
        chk({pfx, "_abort"},       32'(tx_abort), 32'd0);
        chk({pfx, "_proto"},       32'(tx_ip_proto), 32'd0);
        chk({pfx, "_dst"},         tx_ip_dst, 32'd0);
        chk({pfx, "_len"},         32'(tx_ip_len), 32'd0);
        chk({pfx, "_tdata"},       32'(tx_axis_ip_tdata), 32'd0);
        chk({pfx, "_tdest"},       32'(tx_axis_ip_tdest), 32'd0);
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_tvalid"},      32'(tx_axis_ip_tvalid), 32'd0);
        chk({pfx, "_udp_tready"},  32'(udp_axis_tready), 32'd0);
        chk({pfx, "_icmp_tready"}, 32'(icmp_axis_tready), 32'd0);
        chk({pfx, "_busy"},        32'(tx_busy), 32'd0);
    endtask

    // Drives n beats base..base+n-1 from the granted source; tlast on the final
    // beat only when end_pkt. With toggle, downstream tready goes 1,0,1,0...
    task automatic xfer_pkt(input logic src, input int n, input logic [7:0] base,
                            input bit toggle, input bit end_pkt);
        int   k   = 0;
        int   cyc = 0;
        logic rdy;
        logic [7:0]  e_proto = src ? 8'd1 : 8'd17;
        logic [31:0] e_dst   = src ? ICMP_DST : UDP_DST;
        logic [15:0] e_len   = src ? ICMP_LEN : UDP_LEN;
        while (k < n && cyc < 200) begin
            @(negedge clk);
            rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
            tx_axis_ip_tready = rdy;
            drv(src, 1'b1, base + 8'(k), end_pkt && (k == n - 1));
            #1;
            chk("xf_tdata",  32'(tx_axis_ip_tdata), 32'(base + 8'(k)));
            chk("xf_tvalid", 32'(tx_axis_ip_tvalid), 32'd1);
            chk("xf_tlast",  32'(tx_axis_ip_tlast), 32'(end_pkt && (k == n - 1)));
            chk("xf_tuser",  32'(tx_axis_ip_tuser), 32'd0);
            chk("xf_tdest",  32'(tx_axis_ip_tdest), 32'(src));
            chk("xf_proto",  32'(tx_ip_proto), 32'(e_proto));
            chk("xf_dst",    tx_ip_dst, e_dst);
            chk("xf_len",    32'(tx_ip_len), 32'(e_len));
            chk("xf_gnt_tready", 32'(src ? icmp_axis_tready : udp_axis_tready), 32'(rdy));
            chk("xf_oth_tready", 32'(src ? udp_axis_tready : icmp_axis_tready), 32'd0);
            chk("xf_abort",  32'(tx_abort), 32'd0);
            chk("xf_busy",   32'(tx_busy), 32'd1);
            if (rdy) k++;
            cyc++;
        end
        chk("xf_beats_done", 32'(k), 32'(n));
    endtask

    initial begin
        rst               = 1'b1;
        udp_tx_ip_dst     = UDP_DST;
        udp_tx_ip_len     = UDP_LEN;
        icmp_tx_ip_dst    = ICMP_DST;
        icmp_tx_ip_len    = ICMP_LEN;
        udp_axis_tdata    = 8'h00;
        udp_axis_tvalid   = 1'b0;
        udp_axis_tlast    = 1'b0;
        icmp_axis_tdata   = 8'h00;
        icmp_axis_tvalid  = 1'b0;
        icmp_axis_tlast   = 1'b0;
        tx_axis_ip_tready = 1'b0;
        #1;
        chk_reset("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // UDP only, 8 beats 0x01..0x08
        drv(1'b0, 1'b1, 8'h01, 1'b0);
        tx_axis_ip_tready = 1'b1;
        #1;
        chk_idle("t1_req");
        xfer_pkt(1'b0, 8, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        drv(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk_idle("t1_after");
        chk("t1_proto_hold", 32'(tx_ip_proto), 32'd17);
        chk("t1_len_hold",   32'(tx_ip_len), 32'(UDP_LEN));

        // Simultaneous requests after reset: U, I, U, I with 1-cycle gaps
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drv(1'b0, 1'b1, 8'h10, 1'b0);
        drv(1'b1, 1'b1, 8'h20, 1'b0);
        #1;
        chk_idle("t2_req");
        for (int p = 0; p < 4; p++) begin
            if (p > 0) begin
                @(negedge clk);
                #1;
                chk_idle("t2_gap");
            end
            xfer_pkt(1'(p % 2), 4, (p % 2 == 1) ? 8'h20 : 8'h10, 1'b0, 1'b1);
        end

        // ICMP 16 bytes with downstream tready toggling
        @(negedge clk);
        drv(1'b0, 1'b0, 8'h00, 1'b0);
        drv(1'b1, 1'b1, 8'h40, 1'b0);
        #1;
        chk_idle("t3_req");
        xfer_pkt(1'b1, 16, 8'h40, 1'b1, 1'b1);
        @(negedge clk);
        drv(1'b1, 1'b0, 8'h00, 1'b0);
        tx_axis_ip_tready = 1'b1;
        #1;
        chk_idle("t3_after");

        // Watchdog: UDP stalls after 3 bytes, ICMP pending
        @(negedge clk);
        drv(1'b0, 1'b1, 8'h01, 1'b0);
        drv(1'b1, 1'b1, 8'h50, 1'b0);
        #1;
        chk_idle("t4_req");
        xfer_pkt(1'b0, 3, 8'h01, 1'b0, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            drv(1'b0, 1'b0, 8'h00, 1'b0);
            #1;
            chk("t4_empty_tvalid", 32'(tx_axis_ip_tvalid), 32'd0);
            chk("t4_empty_abort",  32'(tx_abort), 32'd0);
            chk("t4_empty_busy",   32'(tx_busy), 32'd1);
        end
        @(negedge clk);
        tx_axis_ip_tready = 1'b0;
        #1;
        chk("t4_abort_pulse",  32'(tx_abort), 32'd1);
        chk("t4_abort_tvalid", 32'(tx_axis_ip_tvalid), 32'd1);
        chk("t4_abort_tlast",  32'(tx_axis_ip_tlast), 32'd1);
        chk("t4_abort_tuser",  32'(tx_axis_ip_tuser), 32'd1);
        chk("t4_abort_tdata",  32'(tx_axis_ip_tdata), 32'd0);
        chk("t4_abort_tdest",  32'(tx_axis_ip_tdest), 32'd0);
        chk("t4_abort_udp_rdy",  32'(udp_axis_tready), 32'd0);
        chk("t4_abort_icmp_rdy", 32'(icmp_axis_tready), 32'd0);
        @(negedge clk);
        tx_axis_ip_tready = 1'b1;
        #1;
        chk("t4_hold_abort",  32'(tx_abort), 32'd0);
        chk("t4_hold_tvalid", 32'(tx_axis_ip_tvalid), 32'd1);
        chk("t4_hold_tuser",  32'(tx_axis_ip_tuser), 32'd1);
        for (int k = 4; k <= 8; k++) begin
            @(negedge clk);
            drv(1'b0, 1'b1, 8'(k), k == 8);
            #1;
            chk("t4_flush_tvalid",   32'(tx_axis_ip_tvalid), 32'd0);
            chk("t4_flush_udp_rdy",  32'(udp_axis_tready), 32'd1);
            chk("t4_flush_icmp_rdy", 32'(icmp_axis_tready), 32'd0);
            chk("t4_flush_busy",     32'(tx_busy), 32'd1);
        end
        @(negedge clk);
        drv(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk_idle("t4_post_flush");
        xfer_pkt(1'b1, 4, 8'h50, 1'b0, 1'b1);

        // Asynchronous reset in the middle of an ICMP packet
        @(negedge clk);
        drv(1'b1, 1'b1, 8'h80, 1'b0);
        #1;
        chk_idle("t5_req");
        xfer_pkt(1'b1, 4, 8'h80, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 1'b1, 8'h84, 1'b0);
        #1;
        chk("t5_byte5_tvalid", 32'(tx_axis_ip_tvalid), 32'd1);
        chk("t5_byte5_tdata",  32'(tx_axis_ip_tdata), 32'h84);
        #1;
        rst = 1'b1;
        #1;
        chk_reset("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        drv(1'b0, 1'b1, 8'h11, 1'b0);
        #1;
        chk_idle("t5_req2");
        @(negedge clk);
        #1;
        chk("t5_gnt_tdest",    32'(tx_axis_ip_tdest), 32'd0);
        chk("t5_gnt_proto",    32'(tx_ip_proto), 32'd17);
        chk("t5_gnt_udp_rdy",  32'(udp_axis_tready), 32'd1);
        chk("t5_gnt_icmp_rdy", 32'(icmp_axis_tready), 32'd0);
        chk("t5_gnt_tdata",    32'(tx_axis_ip_tdata), 32'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ip_tx_arbiter.md
# ip_tx_arbiter

Packet-level arbiter that shares the single IP transmit path between the UDP transmitter and the ICMP (echo-reply) transmitter. It sits between the two protocol TX blocks and the IP TX framer, in the `tx_mac_aclk` domain. It grants whole packets round-robin and presents the winner's stream with latched IP metadata. A stall watchdog aborts and flushes any source that starves mid-packet.

## Interface
- `TIMEOUT_CYC`, default 16'd4096: consecutive cycles with granted-source `tvalid`=0 mid-packet before abort; legal range 1..65535.
- `tx_mac_aclk` in 1: clock.
- `tx_mac_reset` in 1: reset. One clock; reset is asynchronous and active-high.
- `udp_tx_ip_dst` in 32: UDP packet destination IP. Must be stable while `udp_axis_tvalid` is high before the first beat.
- `udp_tx_ip_len` in 16: UDP IP-payload length in bytes, same stability rule.
- `udp_axis_tdata` in 8, `udp_axis_tvalid` in 1, `udp_axis_tlast` in 1, `udp_axis_tready` out 1: UDP byte stream.
- `icmp_tx_ip_dst` in 32, `icmp_tx_ip_len` in 16: ICMP metadata, same rules as UDP.
- `icmp_axis_tdata` in 8, `icmp_axis_tvalid` in 1, `icmp_axis_tlast` in 1, `icmp_axis_tready` out 1: ICMP byte stream.
- `tx_ip_proto` out 8: 17 for UDP, 1 for ICMP. Held for the whole packet.
- `tx_ip_dst` out 32, `tx_ip_len` out 16: latched metadata of the granted packet.
- `tx_axis_ip_tdata` out 8, `tx_axis_ip_tvalid` out 1, `tx_axis_ip_tlast` out 1, `tx_axis_ip_tready` in 1: stream to the IP framer.
- `tx_axis_ip_tuser` out 1: 1 marks an aborted packet. Valid with `tlast`.
- `tx_axis_ip_tdest` out 1: 0 for UDP, 1 for ICMP.
- `tx_busy` out 1: high whenever state ≠ IDLE.
- `tx_abort` out 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, XFER, ABORT, FLUSH.
- **IDLE**
  - All `tready` are 0 and `tx_axis_ip_tvalid` is 0.
  - If any source `tvalid` is high, pick a winner.
    - Single requester: it wins.
    - Both requesting: the source not in `last_grant` wins.
  - Register `grant`, `last_grant`, `tdest`, proto, dst and len, then go to XFER.
- **XFER**
  - Combinational pass-through of the granted source: `tdata`, `tvalid` and `tlast` go out, and `tx_axis_ip_tready` returns to the granted source only. The non-granted `tready` is 0.
  - `tuser` is 0.
  - On a handshake with `tlast`=1, go to IDLE.
  - Watchdog counter (16 bit):
    - Clears on every cycle where the granted `tvalid` is 1.
    - Increments while the granted `tvalid` is 0.
    - Downstream backpressure does not count.
  - When the counter reaches `TIMEOUT_CYC`, go to ABORT and pulse `tx_abort`.
- **ABORT**
  - Drive `tvalid`=1, `tlast`=1, `tuser`=1, `tdata`=8'h00. Both source `tready` are 0.
  - Hold until `tx_axis_ip_tready`, then go to FLUSH.
- **FLUSH**
  - Granted-source `tready`=1; its beats are discarded and `tx_axis_ip_tvalid`=0.
  - On a source beat with `tlast`, go to IDLE.
  - There is no watchdog in FLUSH.
- Metadata outputs hold their last values in IDLE. They update only at grant.

## Timing
- Reset values:
  - State IDLE; `grant` and `last_grant` = ICMP, so UDP wins the first contention.
  - All `tready`, `tvalid`, `tlast`, `tuser`, `tx_busy` and `tx_abort` are 0.
  - `tx_ip_proto`, dst, len, `tdata` and `tdest` are 0.
- Arbitration latency: request seen in cycle N, first beat can handshake in cycle N+1.
- Data latency in XFER: 0 cycles, pure mux with no pipeline register.
- Inter-packet gap: minimum 1 idle cycle after a `tlast` handshake before the next grant takes effect.
- Simultaneous requests in IDLE resolve round-robin with no starvation. A source that drops `tvalid` before grant simply loses its turn.
- Watchdog fires on the `TIMEOUT_CYC`-th consecutive empty cycle: `tx_abort` is high in the first ABORT cycle.
- Asynchronous reset mid-packet: immediate return to reset values. A truncated packet without `tlast` is tolerated because the framer shares the reset.

## Structure
- Shared package `ip_pkg` holds:
  - `IP_PROTO_UDP`=8'd17 and `IP_PROTO_ICMP`=8'd1;
  - `TDEST_UDP`=1'b0 and `TDEST_ICMP`=1'b1, the same encoding as the RX path;
  - FSM state encoding, 2 bits.
- Natural sub-module: `stall_watchdog`, a counter with clear, enable and parameterised terminal count plus a `fire` output. Everything else stays flat.

## Test plan
- UDP only, len 8, 8 beats 0x01..0x08 with `tready`=1 → 8 beats out with `tdest`=0, proto 17, dst/len echoed, `tlast` on 0x08, `tx_busy` low one cycle after.
- UDP and ICMP both valid at the same cycle after reset → UDP packet first, then ICMP after a 1-cycle gap. Repeat → grant alternates U, I, U, I.
- Downstream `tready` toggles 1-0-1-0 during a 16-byte ICMP packet → all 16 bytes in order, no duplicates, no watchdog fire.
- `TIMEOUT_CYC`=10; UDP sends 3 bytes then holds `tvalid`=0:
  - → `tx_abort` pulse on the 10th empty cycle;
  - → forced beat 0x00 with `tlast`=1 and `tuser`=1;
  - → the remaining UDP beats are swallowed up to the source `tlast`;
  - → then a pending ICMP packet is granted.
- Assert `tx_mac_reset` mid-XFER on ICMP byte 5 → all outputs return to reset values asynchronously. After release, a simultaneous request grants UDP first.
